// File: rtl/ctrl_fsm.sv
// ---------------------------------------------------------------------------
// ctrl_fsm -- multi-cycle control unit for the 16-bit CPU.
//
// Sequences FETCH / DECODE / EXEC / MEM / WB, decodes the opcode held in the
// instruction register into an ALU operation plus datapath strobes, keeps the
// architectural {Z,C,N} flag register and resolves conditional branches.
// Every output is decoded from registered state (state, ir_q, flag_q), so
// there is no combinational path from instr or alu_flag to any output.
//
// Ports
//   clk        in   1   clock, rising edge
//   rst_n      in   1   asynchronous active-low reset
//   start      in   1   leave IDLE/HALT and begin fetching
//   instr      in   DW  instruction memory read data, sampled in FETCH
//   alu_flag   in   3   ALU flags {Z,C,N}, sampled at the end of EXEC
//   alucontrol out  4   ALU operation code (0 outside EXEC/MEM/WB)
//   srcb_imm   out  1   ALU operand B select: 1 immediate, 0 register
//   ir_q       out  DW  instruction register
//   pc_inc     out  1   PC += 1 strobe (FETCH)
//   pc_load    out  1   PC <= ALU result strobe (jump / taken branch)
//   reg_we     out  1   register file write strobe (WB)
//   wb_sel     out  1   writeback source: 0 ALU, 1 memory
//   mem_we     out  1   data memory write enable (MEM of STORE)
//   flag_q     out  3   architectural flags {Z,C,N}
//   halted     out  1   high while in HALT
// ---------------------------------------------------------------------------
module ctrl_fsm #(
  parameter int DW       = 16,
  parameter int OPW      = 5,
  parameter int MEM_WAIT = 0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [DW-1:0] instr,
  input  logic [2:0]    alu_flag,
  output logic [3:0]    alucontrol,
  output logic          srcb_imm,
  output logic [DW-1:0] ir_q,
  output logic          pc_inc,
  output logic          pc_load,
  output logic          reg_we,
  output logic          wb_sel,
  output logic          mem_we,
  output logic [2:0]    flag_q,
  output logic          halted
);

  localparam logic [OPW-1:0] OP_NOP   = 5'b00000;
  localparam logic [OPW-1:0] OP_HALT  = 5'b00001;
  localparam logic [OPW-1:0] OP_LOAD  = 5'b00010;
  localparam logic [OPW-1:0] OP_STORE = 5'b00011;
  localparam logic [OPW-1:0] OP_LDIH  = 5'b00100;
  localparam logic [OPW-1:0] OP_ADD   = 5'b00101;
  localparam logic [OPW-1:0] OP_ADDI  = 5'b00110;
  localparam logic [OPW-1:0] OP_ADDC  = 5'b00111;
  localparam logic [OPW-1:0] OP_SUB   = 5'b01000;
  localparam logic [OPW-1:0] OP_SUBI  = 5'b01001;
  localparam logic [OPW-1:0] OP_SUBC  = 5'b01010;
  localparam logic [OPW-1:0] OP_CMP   = 5'b01011;
  localparam logic [OPW-1:0] OP_AND   = 5'b01100;
  localparam logic [OPW-1:0] OP_OR    = 5'b01101;
  localparam logic [OPW-1:0] OP_XOR   = 5'b01110;
  localparam logic [OPW-1:0] OP_SLL   = 5'b01111;
  localparam logic [OPW-1:0] OP_SRL   = 5'b10000;
  localparam logic [OPW-1:0] OP_SLA   = 5'b10001;
  localparam logic [OPW-1:0] OP_SRA   = 5'b10010;
  localparam logic [OPW-1:0] OP_JUMP  = 5'b11000;
  localparam logic [OPW-1:0] OP_JMPR  = 5'b11001;
  localparam logic [OPW-1:0] OP_BZ    = 5'b11010;
  localparam logic [OPW-1:0] OP_BNZ   = 5'b11011;
  localparam logic [OPW-1:0] OP_BN    = 5'b11100;
  localparam logic [OPW-1:0] OP_BNN   = 5'b11101;
  localparam logic [OPW-1:0] OP_BC    = 5'b11110;
  localparam logic [OPW-1:0] OP_BNC   = 5'b11111;

  localparam logic [3:0] MEM_WAIT_C = 4'(MEM_WAIT);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6
  } state_t;

  state_t         state_reg, state_next;
  logic [3:0]     wait_cnt_reg;
  logic [OPW-1:0] opcode;

  // Decoded view of ir_q
  logic [3:0] ac_dec;
  logic       imm_dec;
  logic       is_halt, is_nop, is_cmp, is_jump, is_branch;
  logic       is_load, is_store, is_carry;
  logic       br_taken;

  assign opcode = ir_q[DW-1 -: OPW];

  // -------------------------------------------------------------------------
  // Opcode decode (pure function of ir_q)
  // -------------------------------------------------------------------------
  always_comb begin
    ac_dec    = 4'b0000;
    imm_dec   = 1'b0;
    is_halt   = 1'b0;
    is_nop    = 1'b0;
    is_cmp    = 1'b0;
    is_jump   = 1'b0;
    is_branch = 1'b0;
    is_load   = 1'b0;
    is_store  = 1'b0;
    is_carry  = 1'b0;
    case (opcode)
      OP_NOP:   is_nop = 1'b1;
      OP_HALT:  is_halt = 1'b1;
      OP_LOAD:  begin ac_dec = 4'b0001; imm_dec = 1'b1; is_load  = 1'b1; end
      OP_STORE: begin ac_dec = 4'b0001; imm_dec = 1'b1; is_store = 1'b1; end
      OP_LDIH:  begin ac_dec = 4'b1101; imm_dec = 1'b1; is_carry = 1'b1; end
      OP_ADD:   begin ac_dec = 4'b0001;                 is_carry = 1'b1; end
      OP_ADDI:  begin ac_dec = 4'b0001; imm_dec = 1'b1; is_carry = 1'b1; end
      OP_ADDC:  begin ac_dec = 4'b1010;                 is_carry = 1'b1; end
      OP_SUB:   begin ac_dec = 4'b0010;                 is_carry = 1'b1; end
      OP_SUBI:  begin ac_dec = 4'b0010; imm_dec = 1'b1; is_carry = 1'b1; end
      OP_SUBC:  begin ac_dec = 4'b1011;                 is_carry = 1'b1; end
      OP_CMP:   begin ac_dec = 4'b1100;                 is_cmp   = 1'b1; end
      OP_AND:   ac_dec = 4'b0011;
      OP_OR:    ac_dec = 4'b0100;
      OP_XOR:   ac_dec = 4'b0101;
      OP_SLL:   begin ac_dec = 4'b0110; imm_dec = 1'b1; end
      OP_SRL:   begin ac_dec = 4'b0111; imm_dec = 1'b1; end
      OP_SLA:   begin ac_dec = 4'b1000; imm_dec = 1'b1; end
      OP_SRA:   begin ac_dec = 4'b1001; imm_dec = 1'b1; end
      OP_JUMP, OP_JMPR: begin
        ac_dec = 4'b1110; imm_dec = 1'b1; is_jump = 1'b1;
      end
      OP_BZ, OP_BNZ, OP_BN, OP_BNN, OP_BC, OP_BNC: begin
        ac_dec = 4'b1110; imm_dec = 1'b1; is_branch = 1'b1;
      end
      default:  is_nop = 1'b1;  // unassigned opcodes retire like NOP
    endcase
  end

  // Branch condition on the architectural flags {Z,C,N}
  always_comb begin
    br_taken = 1'b0;
    case (opcode)
      OP_BZ:   br_taken =  flag_q[2];
      OP_BNZ:  br_taken = ~flag_q[2];
      OP_BN:   br_taken =  flag_q[0];
      OP_BNN:  br_taken = ~flag_q[0];
      OP_BC:   br_taken =  flag_q[1];
      OP_BNC:  br_taken = ~flag_q[1];
      default: br_taken = 1'b0;
    endcase
  end

  // -------------------------------------------------------------------------
  // State register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= S_IDLE;
    else        state_reg <= state_next;
  end

  // Instruction register, flags and MEM wait counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ir_q         <= '0;
      flag_q       <= 3'b000;
      wait_cnt_reg <= 4'd0;
    end else begin
      if (state_reg == S_FETCH) ir_q <= instr;
      if (state_reg == S_EXEC) begin
        // CMP owns all three flags; arithmetic only refreshes carry so the
        // carry chain survives logic/shift/memory instructions.
        if (is_cmp)        flag_q    <= alu_flag;
        else if (is_carry) flag_q[1] <= alu_flag[1];
        wait_cnt_reg <= 4'd0;
      end else if (state_reg == S_MEM && wait_cnt_reg < MEM_WAIT_C) begin
        wait_cnt_reg <= wait_cnt_reg + 4'd1;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:   if (start) state_next = S_FETCH;
      S_FETCH:  state_next = S_DECODE;
      S_DECODE: begin
        if (is_halt)     state_next = S_HALT;
        else if (is_nop) state_next = S_FETCH;
        else             state_next = S_EXEC;
      end
      S_EXEC: begin
        if (is_cmp || is_jump || is_branch) state_next = S_FETCH;
        else if (is_load || is_store)       state_next = S_MEM;
        else                                state_next = S_WB;
      end
      S_MEM: begin
        if (wait_cnt_reg < MEM_WAIT_C) state_next = S_MEM;
        else if (is_store)             state_next = S_FETCH;
        else                           state_next = S_WB;
      end
      S_WB:     state_next = S_FETCH;
      S_HALT:   if (start) state_next = S_FETCH;
      default:  state_next = S_IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // Output decode
  // -------------------------------------------------------------------------
  always_comb begin
    logic in_alu;
    in_alu     = (state_reg == S_EXEC) || (state_reg == S_MEM) || (state_reg == S_WB);
    alucontrol = in_alu ? ac_dec : 4'b0000;
    srcb_imm   = in_alu & imm_dec;
    pc_inc     = (state_reg == S_FETCH);
    pc_load    = (state_reg == S_EXEC) & (is_jump | (is_branch & br_taken));
    reg_we     = (state_reg == S_WB);
    wb_sel     = (state_reg == S_WB) & is_load;
    mem_we     = (state_reg == S_MEM) & is_store;
    halted     = (state_reg == S_HALT);
  end

endmodule

// File: tb/tb_ctrl_fsm.sv
// ---------------------------------------------------------------------------
// tb_ctrl_fsm -- self-checking bench for ctrl_fsm (MEM_WAIT = 2).
// Each instruction is expanded by a reference model into its expected
// per-cycle output trace (FETCH, DECODE, EXEC, MEM..., WB or HALT), built
// from the instruction classes and the opcode table; the DUT outputs,
// ir_q and flag_q are compared every cycle on the falling edge.
// ---------------------------------------------------------------------------
module tb_ctrl_fsm;

  localparam int MW = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [15:0] instr;
  logic [2:0]  alu_flag;
  logic [3:0]  alucontrol;
  logic        srcb_imm;
  logic [15:0] ir_q;
  logic        pc_inc, pc_load, reg_we, wb_sel, mem_we, halted;
  logic [2:0]  flag_q;

  ctrl_fsm #(.DW(16), .OPW(5), .MEM_WAIT(MW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .instr(instr),
    .alu_flag(alu_flag), .alucontrol(alucontrol), .srcb_imm(srcb_imm),
    .ir_q(ir_q), .pc_inc(pc_inc), .pc_load(pc_load), .reg_we(reg_we),
    .wb_sel(wb_sel), .mem_we(mem_we), .flag_q(flag_q), .halted(halted)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference architectural state
  logic [15:0] m_ir;
  logic [2:0]  m_flag;

  logic [10:0] obs;
  assign obs = {alucontrol, srcb_imm, pc_inc, pc_load, reg_we, wb_sel, mem_we, halted};

  typedef enum int {K_NOP, K_HALT, K_ALU, K_CARRY, K_CMP, K_JMP, K_BR, K_LOAD, K_STORE} kind_e;

  function automatic logic [10:0] pack(input logic [3:0] ac, input logic imm,
                                       input logic pci, input logic pcl,
                                       input logic rwe, input logic wbs,
                                       input logic mwe, input logic hlt);
    return {ac, imm, pci, pcl, rwe, wbs, mwe, hlt};
  endfunction

  // Instruction-set table: class, ALU code, immediate operand
  function automatic void op_info(input logic [4:0] op, output kind_e k,
                                  output logic [3:0] ac, output logic imm);
    k = K_NOP; ac = 4'h0; imm = 1'b0;
    case (op)
      5'd1:  k = K_HALT;
      5'd2:  begin k = K_LOAD;  ac = 4'h1; imm = 1'b1; end
      5'd3:  begin k = K_STORE; ac = 4'h1; imm = 1'b1; end
      5'd4:  begin k = K_CARRY; ac = 4'hD; imm = 1'b1; end
      5'd5:  begin k = K_CARRY; ac = 4'h1; end
      5'd6:  begin k = K_CARRY; ac = 4'h1; imm = 1'b1; end
      5'd7:  begin k = K_CARRY; ac = 4'hA; end
      5'd8:  begin k = K_CARRY; ac = 4'h2; end
      5'd9:  begin k = K_CARRY; ac = 4'h2; imm = 1'b1; end
      5'd10: begin k = K_CARRY; ac = 4'hB; end
      5'd11: begin k = K_CMP;   ac = 4'hC; end
      5'd12: begin k = K_ALU;   ac = 4'h3; end
      5'd13: begin k = K_ALU;   ac = 4'h4; end
      5'd14: begin k = K_ALU;   ac = 4'h5; end
      5'd15: begin k = K_ALU;   ac = 4'h6; imm = 1'b1; end
      5'd16: begin k = K_ALU;   ac = 4'h7; imm = 1'b1; end
      5'd17: begin k = K_ALU;   ac = 4'h8; imm = 1'b1; end
      5'd18: begin k = K_ALU;   ac = 4'h9; imm = 1'b1; end
      5'd24, 5'd25: begin k = K_JMP; ac = 4'hE; imm = 1'b1; end
      5'd26, 5'd27, 5'd28, 5'd29, 5'd30, 5'd31: begin k = K_BR; ac = 4'hE; imm = 1'b1; end
      default: k = K_NOP;
    endcase
  endfunction

  // Branches come in pairs (set, clear) over Z, N, C in that order.
  function automatic logic branch_taken(input logic [4:0] op, input logic [2:0] f);
    int idx;
    logic bitv;
    idx  = int'(op) - 26;
    bitv = (idx / 2 == 0) ? f[2] : (idx / 2 == 1) ? f[0] : f[1];
    return (idx % 2 == 0) ? bitv : ~bitv;
  endfunction

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  // One clock cycle: sample on the falling edge, then advance past the rising edge.
  task automatic cyc(input string tag, input logic [10:0] e_out);
    @(negedge clk);
    chk({tag, " out"}, 32'(obs), 32'(e_out));
    chk({tag, " ir"}, 32'(ir_q), 32'(m_ir));
    chk({tag, " flag"}, 32'(flag_q), 32'(m_flag));
    @(posedge clk);
    #1;
  endtask

  // Execute one instruction starting in FETCH. fl is presented in EXEC,
  // hold = HALT cycles before the resume pulse, rst_at = MEM cycle index at
  // which reset is asserted (-1 for none).
  task automatic run_instr(input logic [15:0] ins, input logic [2:0] fl,
                           input int hold, input int rst_at, input string tag);
    kind_e      k;
    logic [3:0] ac;
    logic       imm;
    logic [4:0] op;
    logic       pcl;
    op = ins[15:11];
    op_info(op, k, ac, imm);
    $display("instr %s: %h op=%0d class=%s", tag, ins, op, k.name());

    instr = ins; start = 1'($urandom); alu_flag = 3'($urandom);
    cyc({tag, " F"}, pack(4'h0, 0, 1, 0, 0, 0, 0, 0));
    m_ir = ins;

    instr = 16'($urandom); start = 1'($urandom); alu_flag = 3'($urandom);
    cyc({tag, " D"}, pack(4'h0, 0, 0, 0, 0, 0, 0, 0));

    if (k == K_HALT) begin
      start = 1'b0;
      for (int i = 0; i < hold; i++) cyc({tag, " H"}, pack(4'h0, 0, 0, 0, 0, 0, 0, 1));
      start = 1'b1;
      cyc({tag, " Hs"}, pack(4'h0, 0, 0, 0, 0, 0, 0, 1));
      start = 1'b0;
      return;
    end
    if (k == K_NOP) return;

    pcl = (k == K_JMP) || (k == K_BR && branch_taken(op, m_flag));
    alu_flag = fl;
    cyc({tag, " E"}, pack(ac, imm, 0, pcl, 0, 0, 0, 0));
    if (k == K_CMP)   m_flag = fl;
    if (k == K_CARRY) m_flag[1] = fl[1];
    if (k == K_CMP || k == K_JMP || k == K_BR) return;

    if (k == K_LOAD || k == K_STORE) begin
      for (int i = 0; i <= MW; i++) begin
        alu_flag = 3'($urandom); start = 1'($urandom);
        if (i == rst_at) begin
          @(negedge clk);
          chk({tag, " M pre-rst"}, 32'(obs), 32'(pack(ac, imm, 0, 0, 0, 0, k == K_STORE, 0)));
          #2 rst_n = 1'b0;
          #1;
          chk({tag, " rst out"}, 32'(obs), 32'd0);
          chk({tag, " rst flag"}, 32'(flag_q), 32'd0);
          chk({tag, " rst ir"}, 32'(ir_q), 32'd0);
          m_ir = 16'h0; m_flag = 3'b000;
          @(posedge clk);
          #1 rst_n = 1'b1;
          start = 1'b0;
          return;
        end
        cyc({tag, " M"}, pack(ac, imm, 0, 0, 0, 0, k == K_STORE, 0));
      end
      if (k == K_STORE) return;
    end

    alu_flag = 3'($urandom); start = 1'($urandom);
    cyc({tag, " W"}, pack(ac, imm, 0, 0, 1, k == K_LOAD, 0, 0));
  endtask

  initial begin
    logic [15:0] ins;
    rst_n = 1'b0; start = 1'b0; instr = 16'h0; alu_flag = 3'b000;
    m_ir = 16'h0; m_flag = 3'b000;

    // Reset state
    #2;
    chk("reset out", 32'(obs), 32'd0);
    chk("reset ir", 32'(ir_q), 32'd0);
    chk("reset flag", 32'(flag_q), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // IDLE waits for start
    cyc("idle0", 11'd0);
    cyc("idle1", 11'd0);
    start = 1'b1;
    cyc("idle start", 11'd0);

    // 1: ADD
    run_instr(16'h2800, 3'($urandom), 0, -1, "t1 ADD");
    // 2: CMP then branches on the fresh flags
    run_instr(16'h5800, 3'b101, 0, -1, "t2 CMP");
    chk("t2 flag after CMP", 32'(flag_q), 32'd5);
    run_instr(16'hD000, 3'($urandom), 0, -1, "t2 BZ");
    run_instr(16'hD800, 3'($urandom), 0, -1, "t2 BNZ");
    // 3: STORE / LOAD with MEM_WAIT=2
    run_instr(16'h1800, 3'($urandom), 0, -1, "t3 STORE");
    run_instr(16'h1000, 3'($urandom), 0, -1, "t3 LOAD");
    // 4: carry survives AND, then BC
    run_instr(16'h5800, 3'b000, 0, -1, "t4 CMP");
    run_instr(16'h2800, 3'b010, 0, -1, "t4 ADD");
    run_instr(16'h6000, 3'b000, 0, -1, "t4 AND");
    chk("t4 flag after AND", 32'(flag_q), 32'd2);
    run_instr(16'hF000, 3'($urandom), 0, -1, "t4 BC");
    // 5: HALT held 10 cycles, resume
    run_instr(16'h0800, 3'($urandom), 10, -1, "t5 HALT");
    run_instr(16'h2800, 3'($urandom), 0, -1, "t5 ADD");
    // NOP and unassigned opcode
    run_instr(16'h0000, 3'($urandom), 0, -1, "NOP");
    run_instr(16'h9800, 3'($urandom), 0, -1, "UNDEF");

    // Random instruction stream
    for (int n = 0; n < 40; n++) begin
      ins = 16'($urandom);
      run_instr(ins, 3'($urandom), $urandom_range(0, 3), -1, $sformatf("rnd%0d", n));
    end

    // 6: reset in the middle of a STORE's MEM phase
    run_instr(16'h5800, 3'b111, 0, -1, "t6 CMP");
    run_instr(16'h1800, 3'($urandom), 0, 1, "t6 STORE");
    start = 1'b0;
    cyc("t6 idle", 11'd0);
    start = 1'b1;
    cyc("t6 idle start", 11'd0);
    run_instr(16'h3000, 3'b010, 0, -1, "t6 ADDI");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
